// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width, ALU opcodes and multiply-sequencer states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011
    } aluop_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SLL  = 3'd2,
        SRL  = 3'd3,
        DONE = 3'd4
    } mulseq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shares one ALU between the execute stage (absolute priority) and a
// shift-add multiply engine that borrows the ALU only when the pipeline is idle.
module alu_mul_sequencer
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    input  aluop_t            ex_aluop,
    input  logic [DATA_W-1:0] ex_in1,
    input  logic [DATA_W-1:0] ex_in2,
    output logic [DATA_W-1:0] ex_out,
    input  logic              mul_req,
    input  logic              mul_abort,
    input  logic [DATA_W-1:0] mul_a,
    input  logic [DATA_W-1:0] mul_b,
    output logic              mul_busy,
    output logic              mul_done,
    output logic [DATA_W-1:0] mul_result,
    output aluop_t            alu_aluop,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out
);

    mulseq_state_t     r_state;
    mulseq_state_t     w_next;
    logic [DATA_W-1:0] r_m;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;
    logic              r_busy;
    logic              r_done;

    logic              w_need_alu;
    logic              w_stall;
    logic              w_accept;
    logic              w_step;
    aluop_t            w_eng_op;
    logic [DATA_W-1:0] w_eng_in1;
    logic [DATA_W-1:0] w_eng_in2;

    assign w_stall  = w_need_alu && ex_valid;
    assign w_accept = (r_state == IDLE) && mul_req && !mul_abort;
    assign w_step   = !w_stall && !mul_abort;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort beats everything outside IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (mul_req && !mul_abort) w_next = ADD;
            ADD: begin
                if (r_q == '0) begin
                    w_next = DONE;
                end else if (!w_stall) begin
                    w_next = SLL;
                end
            end
            SLL:     if (!w_stall) w_next = SRL;
            SRL:     if (!w_stall) w_next = ADD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (mul_abort && (r_state != IDLE)) begin
            w_next = IDLE;
        end
    end

    // Engine ALU request for the current state
    always_comb begin
        w_need_alu = 1'b0;
        w_eng_op   = ALU_ADD;
        w_eng_in1  = r_acc;
        w_eng_in2  = r_m;
        case (r_state)
            ADD: w_need_alu = (r_q != '0) && r_q[0];
            SLL: begin
                w_need_alu = 1'b1;
                w_eng_op   = ALU_SLL;
                w_eng_in1  = r_m;
                w_eng_in2  = DATA_W'(1);
            end
            SRL: begin
                w_need_alu = 1'b1;
                w_eng_op   = ALU_SRL;
                w_eng_in1  = r_q;
                w_eng_in2  = DATA_W'(1);
            end
            default: w_need_alu = 1'b0;
        endcase
    end

    // Pipeline owns the ALU whenever it is valid or the engine has no use for it
    assign alu_aluop = (ex_valid || !w_need_alu) ? ex_aluop : w_eng_op;
    assign alu_in1   = (ex_valid || !w_need_alu) ? ex_in1   : w_eng_in1;
    assign alu_in2   = (ex_valid || !w_need_alu) ? ex_in2   : w_eng_in2;
    assign ex_out    = alu_out;

    // Multiplicand, multiplier, accumulator and status registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_m      <= '0;
            r_q      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m   <= mul_a;
                r_q   <= mul_b;
                r_acc <= '0;
            end else if (w_step) begin
                case (r_state)
                    ADD:     if (w_need_alu) r_acc <= alu_out;
                    SLL:     r_m <= alu_out;
                    SRL:     r_q <= alu_out;
                    default: ;
                endcase
            end
            if ((r_state == ADD) && (w_next == DONE)) begin
                r_result <= r_acc;
            end
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == DONE);
        end
    end

    assign mul_busy   = r_busy;
    assign mul_done   = r_done;
    assign mul_result = r_result;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural ALU and a
// bit-schedule reference model of the multiply engine.
module tb_alu_mul_sequencer;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ex_valid;
    aluop_t      ex_aluop;
    logic [31:0] ex_in1, ex_in2, ex_out;
    logic        mul_req, mul_abort;
    logic [31:0] mul_a, mul_b;
    logic        mul_busy, mul_done;
    logic [31:0] mul_result;
    aluop_t      alu_aluop;
    logic [31:0] alu_in1, alu_in2, alu_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_prod = 32'd0;

    alu_mul_sequencer #(.DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_out(ex_out),
        .mul_req(mul_req), .mul_abort(mul_abort), .mul_a(mul_a), .mul_b(mul_b),
        .mul_busy(mul_busy), .mul_done(mul_done), .mul_result(mul_result),
        .alu_aluop(alu_aluop), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] alu_fn(input aluop_t op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            ALU_SLL:  return x << y[4:0];
            ALU_SRL:  return x >> y[4:0];
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_AND:  return x & y;
            ALU_OR:   return x | y;
            ALU_XOR:  return x ^ y;
            ALU_NOR:  return ~(x | y);
            ALU_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (x < y) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_aluop, alu_in1, alu_in2);

    function automatic aluop_t rand_op();
        int v;
        v = int'($urandom_range(0, 9));
        if (v > 7) v = v + 2;
        return aluop_t'(4'(v));
    endfunction

    // Runs one multiply from IDLE; ex_valid per cycle comes from vmask.
    // The engine is modelled as a list of steps derived from b's bits.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [127:0] vmask,
                           input bit scripted, output int done_cyc);
        bit     need_q[$];
        aluop_t op_q[$];
        logic [31:0] exp_p;
        int h, cyc, idx, stalls;
        h = -1;
        for (int i = 0; i < 32; i++) if (b[i]) h = i;
        for (int i = 0; i <= h; i++) begin
            need_q.push_back(b[i]); op_q.push_back(ALU_ADD);
            need_q.push_back(1'b1); op_q.push_back(ALU_SLL);
            need_q.push_back(1'b1); op_q.push_back(ALU_SRL);
        end
        need_q.push_back(1'b0); op_q.push_back(ALU_ADD);
        exp_p = a * b;
        mul_a = a; mul_b = b; mul_req = 1'b1; mul_abort = 1'b0; ex_valid = 1'b0;
        @(posedge CLK); #1;
        cyc = 1; idx = 0; stalls = 0; done_cyc = -1;
        while (cyc < 300) begin
            mul_a = $urandom; mul_b = $urandom;
            ex_valid = (cyc < 128) ? vmask[cyc] : 1'b0;
            if (scripted) begin
                ex_aluop = ALU_SUB; ex_in1 = 32'd9; ex_in2 = 32'd4;
            end else begin
                ex_aluop = rand_op(); ex_in1 = $urandom; ex_in2 = $urandom;
            end
            #1;
            if (idx == need_q.size()) begin
                checks++;
                if (mul_done !== 1'b1) begin errors++; $display("FAIL done_pulse a=%h b=%h cyc=%0d got=%b want=1", a, b, cyc, mul_done); end
                checks++;
                if (mul_result !== exp_p) begin errors++; $display("FAIL product a=%h b=%h got=%h want=%h", a, b, mul_result, exp_p); end
                checks++;
                if (cyc !== 3 * (h + 1) + 2 + stalls) begin errors++; $display("FAIL latency a=%h b=%h got=%0d want=%0d", a, b, cyc, 3 * (h + 1) + 2 + stalls); end
                done_cyc = cyc;
                break;
            end
            checks++;
            if (mul_done !== 1'b0 || mul_busy !== 1'b1) begin
                errors++; $display("FAIL busy_phase cyc=%0d got done=%b busy=%b want done=0 busy=1", cyc, mul_done, mul_busy);
            end
            checks++;
            if (ex_valid || !need_q[idx]) begin
                if (alu_aluop !== ex_aluop || alu_in1 !== ex_in1 || alu_in2 !== ex_in2) begin
                    errors++; $display("FAIL mux_pipe cyc=%0d got op=%0d in1=%h in2=%h want op=%0d in1=%h in2=%h",
                                       cyc, alu_aluop, alu_in1, alu_in2, ex_aluop, ex_in1, ex_in2);
                end
            end else begin
                if (alu_aluop !== op_q[idx]) begin
                    errors++; $display("FAIL mux_engine cyc=%0d got op=%0d want op=%0d", cyc, alu_aluop, op_q[idx]);
                end
            end
            if (ex_valid) begin
                checks++;
                if (ex_out !== alu_fn(ex_aluop, ex_in1, ex_in2)) begin
                    errors++; $display("FAIL ex_out cyc=%0d got=%h want=%h", cyc, ex_out, alu_fn(ex_aluop, ex_in1, ex_in2));
                end
            end
            if (need_q[idx] && ex_valid) stalls++; else idx++;
            @(posedge CLK); #1;
            cyc++;
        end
        if (done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL timeout a=%h b=%h got no done want done", a, b);
        end
        // mul_req still high through DONE: must not restart
        ex_valid = 1'b0;
        @(posedge CLK); #1;
        mul_req = 1'b0;
        #1;
        checks++;
        if (mul_busy !== 1'b0 || mul_done !== 1'b0 || mul_result !== exp_p) begin
            errors++; $display("FAIL after_done got busy=%b done=%b res=%h want busy=0 done=0 res=%h", mul_busy, mul_done, mul_result, exp_p);
        end
        last_prod = exp_p;
    endtask

    task automatic test_reset();
        nRST = 1'b0; ex_valid = 1'b1; ex_aluop = ALU_ADD; ex_in1 = 32'd5; ex_in2 = 32'd3;
        mul_req = 1'b0; mul_abort = 1'b0; mul_a = '0; mul_b = '0;
        #3;
        checks++;
        if (mul_busy !== 1'b0 || mul_done !== 1'b0 || mul_result !== 32'd0) begin
            errors++; $display("FAIL reset_outputs got busy=%b done=%b res=%h want 0 0 0", mul_busy, mul_done, mul_result);
        end
        checks++;
        if (ex_out !== 32'd8) begin errors++; $display("FAIL reset_passthru got=%h want=8", ex_out); end
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;
        ex_valid = 1'b0;
    endtask

    task automatic test_basic();
        int dc;
        run_mul(32'd7, 32'd6, 128'd0, 1'b0, dc);
        checks++;
        if (dc !== 11) begin errors++; $display("FAIL basic_cycle got=%0d want=11", dc); end
    endtask

    task automatic test_zero();
        int dc;
        run_mul(32'd123, 32'd0, 128'd0, 1'b0, dc);
        checks++;
        if (dc !== 2) begin errors++; $display("FAIL zero_cycle got=%0d want=2", dc); end
    endtask

    task automatic test_max();
        int dc;
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 128'd0, 1'b0, dc);
        checks++;
        if (dc !== 98 || last_prod !== 32'd1) begin errors++; $display("FAIL max_case got cyc=%0d want cyc=98", dc); end
    endtask

    task automatic test_stall();
        int dc;
        logic [127:0] m;
        m = '0;
        m[1] = 1'b1; m[2] = 1'b1; m[4] = 1'b1; m[5] = 1'b1;
        run_mul(32'd3, 32'd5, m, 1'b1, dc);
        checks++;
        if (dc !== 15) begin errors++; $display("FAIL stall_cycle got=%0d want=15", dc); end
    endtask

    task automatic test_random();
        int dc;
        logic [31:0] a, b;
        logic [127:0] m;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
            m = {$urandom, $urandom, $urandom, $urandom};
            run_mul(a, b, m, 1'b0, dc);
        end
    endtask

    // Starts 9*9 and returns at the start of cycle 4 after the accept edge
    task automatic start_nine();
        mul_a = 32'd9; mul_b = 32'd9; mul_req = 1'b1; ex_valid = 1'b0;
        @(posedge CLK); #1;
        mul_req = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
    endtask

    task automatic test_abort();
        int dc;
        start_nine();
        mul_abort = 1'b1;
        #1;
        checks++;
        if (mul_busy !== 1'b1) begin errors++; $display("FAIL abort_pre got busy=%b want=1", mul_busy); end
        @(posedge CLK); #1;
        mul_abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (mul_busy !== 1'b0 || mul_done !== 1'b0 || mul_result !== last_prod) begin
                errors++; $display("FAIL abort_idle got busy=%b done=%b res=%h want 0 0 %h", mul_busy, mul_done, mul_result, last_prod);
            end
            @(posedge CLK); #1;
        end
        run_mul(32'd2, 32'd2, 128'd0, 1'b0, dc);
        checks++;
        if (dc !== 8) begin errors++; $display("FAIL post_abort_cycle got=%0d want=8", dc); end
        // abort wins over a request in IDLE
        mul_req = 1'b1; mul_abort = 1'b1;
        @(posedge CLK); #1;
        mul_req = 1'b0; mul_abort = 1'b0;
        checks++;
        if (mul_busy !== 1'b0) begin errors++; $display("FAIL abort_in_idle got busy=%b want=0", mul_busy); end
    endtask

    task automatic test_reset_midop();
        int dc;
        start_nine();
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (mul_busy !== 1'b0 || mul_done !== 1'b0 || mul_result !== 32'd0) begin
            errors++; $display("FAIL midop_reset got busy=%b done=%b res=%h want 0 0 0", mul_busy, mul_done, mul_result);
        end
        @(negedge CLK); nRST = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            checks++;
            if (mul_busy !== 1'b0 || mul_done !== 1'b0) begin
                errors++; $display("FAIL midop_idle got busy=%b done=%b want 0 0", mul_busy, mul_done);
            end
        end
        run_mul(32'd2, 32'd2, 128'd0, 1'b0, dc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_stall();
        test_abort();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Shares the single 32-bit ALU between the execute stage and an iterative multiply engine. The engine computes MUL (low 32 bits of a*b) by shift-add, issuing ALU_ADD, ALU_SLL and ALU_SRL operations.
- The execute stage has absolute priority. The engine stalls in place whenever the pipeline claims the ALU.
- Sits between the execute-stage operand muxes and the alu instance. Pipeline-facing ALU path is zero-latency pass-through.

Parameters:
- DATA_W, 32, operand/result width; must equal WORD_W of cpu_types_pkg.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage uses ALU this cycle
- ex_aluop  in  aluop_t  pipeline ALU opcode
- ex_in1  in  DATA_W  pipeline operand 1
- ex_in2  in  DATA_W  pipeline operand 2
- ex_out  out  DATA_W  ALU result returned to pipeline (= alu_out)
- mul_req  in  1  start multiply; sampled only in IDLE
- mul_abort  in  1  cancel in-flight multiply
- mul_a  in  DATA_W  multiplicand
- mul_b  in  DATA_W  multiplier
- mul_busy  out  1  engine not IDLE
- mul_done  out  1  one-cycle pulse, result valid
- mul_result  out  DATA_W  product low word, registered
- alu_aluop  out  aluop_t  to alu
- alu_in1  out  DATA_W  to alu
- alu_in2  out  DATA_W  to alu
- alu_out  in  DATA_W  from alu

Behaviour:
- Reset (nRST=0, async): state=IDLE; internal M, Q, ACC = 0; mul_result=0; mul_busy=0; mul_done=0.
- ALU mux (combinational): if ex_valid or engine needs no ALU this cycle, drive ex_aluop/ex_in1/ex_in2. Otherwise drive the engine's op. ex_out = alu_out always.
- Engine needs the ALU in ADD with Q!=0 and Q[0]=1, and in every SLL/SRL cycle. If ex_valid=1 in such a cycle, hold state and registers (stall).
- IDLE: mul_req=1 and mul_abort=0 -> latch M=mul_a, Q=mul_b, ACC=0; go to ADD.
- ADD:
  - Q==0 -> DONE.
  - Q[0]==0 -> SLL, no ALU use.
  - Q[0]==1 -> ALU_ADD(ACC, M), ACC<=alu_out, then SLL.
- SLL: ALU_SLL(M, 1), M<=alu_out, then SRL.
- SRL: ALU_SRL(Q, 1), Q<=alu_out, then ADD.
- On the transition into DONE, mul_result<=ACC.
- DONE: mul_done=1 for exactly one cycle, then IDLE. mul_req in DONE is ignored.
- mul_busy=1 in ADD, SLL, SRL and DONE.
- Latency without stalls: let h = index of highest set bit of mul_b, with h=-1 when b=0. mul_done asserts 3(h+1)+2 cycles after the accept edge. Each stall cycle adds one.
- Arithmetic: modulo 2^32. ALU over_f is not an input and is ignored; bits above 31 are discarded.
- mul_abort=1 in any non-IDLE state -> IDLE next edge. No mul_done pulse; mul_result keeps its previous value.
- mul_abort in IDLE wins over mul_req: the request is not accepted.
- mul_req while busy: ignored. The requester holds it until mul_busy=0.
- Mid-operation nRST: immediate return to reset values, no done pulse.
- Reserved/unused state encodings -> IDLE.

Decomposition:
- cpu_types_pkg: reuse aluop_t and WORD_W. Add mulseq_state_t enum {IDLE, ADD, SLL, SRL, DONE}.
- No sub-module. The alu instance stays outside; this block contains only the FSM, the M/Q/ACC/result registers and the mux.

Test Plan:
- Reset: assert nRST=0 mid-cycle -> all outputs 0 immediately; with ex_valid=1, ALU_ADD 5+3 -> ex_out=8 the same cycle.
- a=7, b=6, ex_valid=0 -> mul_done at cycle 11 after accept, mul_result=42, mul_busy low the next cycle.
- a=123, b=0 -> mul_done at cycle 2, mul_result=0; alu_* always equal ex_* during the operation.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> mul_result=0x00000001, mul_done at cycle 98.
- a=3, b=5, ex_valid=1 on 4 engine ALU cycles (including SLL) -> mul_done at cycle 15, mul_result=15. During stalls, ex_out tracks pipeline ops (e.g. ALU_SUB 9-4=5).
- Start a=9, b=9, assert mul_abort at cycle 4 -> IDLE at cycle 5, no done, mul_result unchanged. New req a=2, b=2 -> mul_result=4. Repeat with nRST pulse at cycle 4 -> reset state.
